mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Parametrised control unit for the sequential shift-add multiplier datapath (accumulator A, X bit, multiplier register B, adder/subtractor).
- Successor to the fixed 8-bit, one-state-per-step controller. A counter-driven FSM replaces the unrolled state list.
- New over the previous generation: operand width is a parameter; signed/unsigned mode is selectable; A is auto-cleared at start; a real completion flag and busy/count status are provided.

Parameters:
- WIDTH, 8, operand width in bits = number of add/shift iterations; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset; forces IDLE.
- Run  input  1  start request, level; synchronised upstream.
- ClearA_LoadB  input  1  load/clear request, honoured in IDLE only.
- m  input  1  current multiplier LSB (B[0]) from the datapath.
- Signed_mode  input  1  1 = two's-complement multiply, 0 = unsigned; sampled on the Run edge.
- Clr_Ld  output  1  clear A/X and load B; equals ClearA_LoadB in IDLE, else 0.
- ClrA  output  1  clear A and X only; one-cycle pulse at start.
- Shift  output  1  arithmetic right shift of X:A:B.
- Add  output  1  A <= A + S, X <= sign of the sum.
- Sub  output  1  A <= A - S, X <= sign of the difference.
- fin  output  1  product valid, held until Run drops.
- Busy  output  1  high in CLRA, ADD and SHIFT.
- Count  output  CNT_W  completed shift count.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State IDLE, counter 0, registered signed flag 0.
  - Outputs: Shift=Add=Sub=ClrA=fin=Busy=0, Count=0; Clr_Ld follows ClearA_LoadB.
  - Reset mid-operation aborts immediately; datapath contents are don't-care.
- The FSM is Moore-style except for the Add/Sub dependence on m, and Clr_Ld passthrough in IDLE.
- States and transitions:
  - IDLE:
    - Clr_Ld = ClearA_LoadB.
    - Run=1 -> CLRA; latch Signed_mode; counter <= 0.
  - CLRA:
    - ClrA=1, Busy=1.
    - -> ADD unconditionally.
  - ADD:
    - Busy=1.
    - If counter < WIDTH-1, or signed flag = 0: Add=m, Sub=0.
    - If counter == WIDTH-1 and signed flag = 1: Sub=m, Add=0.
    - -> SHIFT.
  - SHIFT:
    - Shift=1, Busy=1, counter <= counter+1.
    - counter == WIDTH-1 -> HOLD; else -> ADD.
  - HOLD:
    - fin=1, Busy=0.
    - Run=0 -> IDLE; Run=1 -> stay.
    - Re-start requires Run low, then high again.
- Latency (baseline): Run sampled high in IDLE -> fin high 2*WIDTH+2 edges later (CLRA + 2*WIDTH ops + HOLD entry). WIDTH=8 gives 18.
- Only one of Add/Sub/Shift/ClrA is ever high in a cycle.
- Count is the registered counter value: 0 in IDLE/CLRA, WIDTH in HOLD, never wraps.
- Boundary conditions:
  - Run dropping during CLRA/ADD/SHIFT is ignored; the operation completes, then HOLD exits on the next cycle.
  - ClearA_LoadB outside IDLE is ignored.
  - Signed_mode changes after the start edge have no effect.

Optional Feature:
- Macro MULT_SEQ_CTRL_SKIP_ZERO_EN.
- Defined: in ADD with m=0, no arithmetic cycle is spent:
  - ADD asserts Shift=1 (Add=Sub=0) and increments the counter.
  - Next state is ADD, or HOLD if the counter was WIDTH-1.
  - ADD with m=1 behaves as baseline.
  - Latency = WIDTH+2 + (number of 1 bits seen in m).
- Undefined: baseline fixed latency 2*WIDTH+2; Shift is never asserted in ADD.

Test Plan:
- Reset during SHIFT of iteration 3 (WIDTH=8) -> same cycle: all outputs 0, Count=0, state IDLE; Run held high -> CLRA next edge.
- WIDTH=8, unsigned, m=1 every ADD -> Add high in 8 ADD cycles, Sub never high; fin at edge 18; Count=8 in HOLD.
- WIDTH=8, signed, m=1 every ADD -> Add in ADD cycles 1-7, Sub in ADD cycle 8; fin at edge 18; Count=8.
- WIDTH=4, Run held high through HOLD for 5 cycles, then low -> fin stays 1 for those 5 cycles, IDLE on next edge; no restart without a new rising Run.
- IDLE, ClearA_LoadB=1 -> Clr_Ld=1 same cycle; ClearA_LoadB=1 during ADD -> Clr_Ld=0.
- SKIP_ZERO_EN defined, WIDTH=8, m pattern 1,0,0,0,0,0,0,1 (signed) -> Add once, Sub once, Shift 8 times; fin at edge 12.

Source files
------------

// File: rtl/mult_seq_ctrl_if.sv
// Request/status bundle between the shift-add multiplier controller and its datapath.
// master = requester/datapath side, slave = controller side.
interface mult_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             Run;
  logic             ClearA_LoadB;
  logic             m;
  logic             Signed_mode;
  logic             Clr_Ld;
  logic             ClrA;
  logic             Shift;
  logic             Add;
  logic             Sub;
  logic             fin;
  logic             Busy;
  logic [CNT_W-1:0] Count;

  modport master (
    output Run, ClearA_LoadB, m, Signed_mode,
    input  Clr_Ld, ClrA, Shift, Add, Sub, fin, Busy, Count
  );

  modport slave (
    input  Run, ClearA_LoadB, m, Signed_mode,
    output Clr_Ld, ClrA, Shift, Add, Sub, fin, Busy, Count
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Counter-driven controller for the sequential shift-add multiplier (A, X, B, add/sub).
// Optional MULT_SEQ_CTRL_SKIP_ZERO_EN: an ADD step with m=0 shifts directly instead of idling.
module mult_seq_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           Clk,
  input  logic           Reset_n,
  mult_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRA  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;

  logic clr_ld, clr_a, shift, add, sub, fin, busy;
  logic last_step;

  // The final iteration carries the sign weight of a two's-complement multiplier.
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    clr_ld  = 1'b0;
    clr_a   = 1'b0;
    shift   = 1'b0;
    add     = 1'b0;
    sub     = 1'b0;
    fin     = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_ld = bus.ClearA_LoadB;
        cnt_d  = '0;
        if (bus.Run) begin
          state_d = CLRA;
          sgn_d   = bus.Signed_mode;
        end
      end
      CLRA: begin
        clr_a   = 1'b1;
        busy    = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        busy = 1'b1;
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
        if (!bus.m) begin
          shift   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = last_step ? HOLD : ADD;
        end else begin
          add     = !(last_step && sgn_q);
          sub     = last_step && sgn_q;
          state_d = SHIFT;
        end
`else
        add     = bus.m && !(last_step && sgn_q);
        sub     = bus.m && last_step && sgn_q;
        state_d = SHIFT;
`endif
      end
      SHIFT: begin
        shift   = 1'b1;
        busy    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last_step ? HOLD : ADD;
      end
      HOLD: begin
        fin = 1'b1;
        // Leaving HOLD returns Count to 0 so IDLE always reports a clean status.
        if (!bus.Run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.Clr_Ld = clr_ld;
  assign bus.ClrA   = clr_a;
  assign bus.Shift  = shift;
  assign bus.Add    = add;
  assign bus.Sub    = sub;
  assign bus.fin    = fin;
  assign bus.Busy   = busy;
  assign bus.Count  = cnt_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomised bench for mult_seq_ctrl: per-cycle expected control words derived from the multiplier bits.
module tb_mult_seq_ctrl;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic          clr_ld;
    logic          clra;
    logic          add;
    logic          sub;
    logic          shift;
    logic          busy;
    logic          fin;
    logic [CW-1:0] cnt;
  } obs_t;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [W-1:0] b_reg = '0;
  int           checks = 0;
  int           failures = 0;

  mult_seq_ctrl_if #(.CNT_W(CW)) bus ();
  mult_seq_ctrl #(.WIDTH(W)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;
  assign bus.m = b_reg[0];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.clr_ld = bus.Clr_Ld;
    o.clra   = bus.ClrA;
    o.add    = bus.Add;
    o.sub    = bus.Sub;
    o.shift  = bus.Shift;
    o.busy   = bus.Busy;
    o.fin    = bus.fin;
    o.cnt    = bus.Count;
    return o;
  endfunction

  function automatic obs_t mk(bit cl, bit ca, bit ad, bit su, bit sh, bit bu, bit fi, int c);
    obs_t r;
    r.clr_ld = cl; r.clra = ca; r.add = ad; r.sub = su;
    r.shift = sh; r.busy = bu; r.fin = fi; r.cnt = CW'(c);
    return r;
  endfunction

  // One full multiply: load B, start, follow every cycle to HOLD and back to IDLE.
  task automatic run_op(input logic [W-1:0] b, input bit s, input int hold_n, input bit drop, input int opn);
    obs_t q[$];
    obs_t o;
    int   nbusy, nhold, drop_at, edges, fin_edge, lat_exp;
    bit   sh, sgn_last;
    bus.ClearA_LoadB = 1'b1;
    #1;
    check_val($sformatf("op%0d_clrld_idle", opn), 32'(bus.Clr_Ld), 32'd1);
    @(posedge Clk); #1;
    b_reg = b;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    check_val($sformatf("op%0d_idle_pre", opn), 32'(observe()), 32'(mk(0,0,0,0,0,0,0,0)));

    q.push_back(mk(0,1,0,0,0,1,0,0));
    for (int i = 0; i < W; i++) begin
      sgn_last = s && (i == W - 1);
      if (SKIP && !b[i]) begin
        q.push_back(mk(0,0,0,0,1,1,0,i));
      end else begin
        q.push_back(mk(0,0,b[i] && !sgn_last,b[i] && sgn_last,0,1,0,i));
        q.push_back(mk(0,0,0,0,1,1,0,i));
      end
    end
    nbusy = q.size();
    nhold = drop ? 1 : hold_n;
    for (int h = 0; h < nhold; h++) q.push_back(mk(0,0,0,0,0,0,1,W));
    q.push_back(mk(0,0,0,0,0,0,0,0));
    q.push_back(mk(0,0,0,0,0,0,0,0));
    drop_at  = drop ? int'($urandom_range(0, nbusy - 1)) : -1;
    lat_exp  = SKIP ? (W + 2 + $countones(b)) : (2 * W + 2);
    edges    = 0;
    fin_edge = -1;
    sh       = 1'b0;

    bus.Run = 1'b1;
    bus.Signed_mode = s;
    for (int k = 0; k < q.size(); k++) begin
      @(posedge Clk); #1;
      edges++;
      if (sh) b_reg = b_reg >> 1;
      @(negedge Clk);
      o = observe();
      if (o.fin && fin_edge < 0) fin_edge = edges;
      check_val($sformatf("op%0d_cyc%0d", opn, k), 32'(o), 32'(q[k]));
      sh = o.shift;
      bus.Signed_mode = 1'($urandom);
      bus.ClearA_LoadB = (k < nbusy - 1) ? 1'($urandom) : 1'b0;
      if (drop_at >= 0 && k >= drop_at) bus.Run = 1'b0;
      if (k >= nbusy + nhold - 1) bus.Run = 1'b0;
    end
    check_val($sformatf("op%0d_latency", opn), 32'(fin_edge), 32'(lat_exp));
  endtask

  // Asynchronous reset landing in SHIFT of iteration 3, with Run still high.
  task automatic reset_mid_op();
    obs_t o;
    bus.ClearA_LoadB = 1'b1;
    @(posedge Clk); #1;
    b_reg = '1;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    bus.Run = 1'b1;
    bus.Signed_mode = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge Clk); #1;
      if (bus.Shift) b_reg = b_reg >> 1;
      @(negedge Clk);
    end
    check_val("rst_pre_shift3", 32'(observe()), 32'(mk(0,0,0,0,1,1,0,3)));
    #2 Reset_n = 1'b0;
    #1;
    o = observe();
    check_val("rst_async_outputs", 32'(o), 32'(mk(0,0,0,0,0,0,0,0)));
    #1 Reset_n = 1'b1;
    @(posedge Clk); #1;
    check_val("rst_restart_clra", 32'(observe()), 32'(mk(0,1,0,0,0,1,0,0)));
    @(negedge Clk);
    bus.Run = 1'b0;
    Reset_n = 1'b0;
    #1 Reset_n = 1'b1;
  endtask

  initial begin
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    bus.Signed_mode = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_val("reset_outputs", 32'(observe()), 32'(mk(0,0,0,0,0,0,0,0)));
    bus.ClearA_LoadB = 1'b1;
    #1;
    check_val("reset_clrld_follows", 32'(bus.Clr_Ld), 32'd1);
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;

    run_op('1, 1'b0, 1, 1'b0, 0);
    run_op('1, 1'b1, 1, 1'b0, 1);
    run_op(W'(8'h81), 1'b1, 2, 1'b0, 2);
    run_op(W'(8'h5a), 1'b0, 5, 1'b0, 3);
    run_op(W'(8'h96), 1'b1, 3, 1'b1, 4);
    run_op('0, 1'b1, 1, 1'b0, 5);
    reset_mid_op();
    @(negedge Clk);
    for (int n = 6; n < 36; n++)
      run_op(W'($urandom), 1'($urandom), int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0), n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
